corescore_uart_emitter: RTL and testbench

Parametrised stream-to-UART emitter that replaces the fixed-format byte emitter at the end of the corescore output chain. It accepts an AXI-stream-style byte channel from the core aggregator and buffers it in an internal FIFO. It serialises each byte with configurable data width, parity, stop bits and baud divisor. An optional end-of-line mode appends CR/LF after every tlast beat.

---
 rtl/corescore_uart_emitter_pkg.sv | 32 +++
 rtl/corescore_uart_emitter_fifo.sv | 55 +++++
 rtl/corescore_uart_emitter.sv | 194 +++++++++++++++++++
 tb/tb_corescore_uart_emitter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/corescore_uart_emitter_pkg.sv
// Shared types and helpers for the corescore stream-to-UART emitter.
// The baud divisor is rounded to the nearest whole clock count.
package corescore_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } uart_state_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_t;

    typedef enum logic [1:0] {
        EOL_NONE,
        EOL_CR,
        EOL_LF
    } eol_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    function automatic int uart_div(input int clk, input int baud);
        return (clk + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/corescore_uart_emitter_fifo.sv
// Synchronous FIFO with registered occupancy count and async active-high reset.
// Pointers wrap naturally because DEPTH is a power of two.
module corescore_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level + LW'(push_ok) - LW'(pop_ok);
        end
    end

endmodule

// File: rtl/corescore_uart_emitter.sv
// Stream-to-UART emitter: buffers stream bytes in a FIFO and serialises them
// with configurable width, parity and stop bits, optionally adding CR/LF after tlast.
module corescore_uart_emitter
    import corescore_uart_pkg::*;
#(
    parameter int DW          = 8,
    parameter int DEPTH       = 16,
    parameter int CLK_FREQ_HZ = 16000000,
    parameter int BAUD        = 57600,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int EOL_MODE    = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [7:0]               i_tdata,
    input  logic                     i_tlast,
    input  logic                     i_tvalid,
    output logic                     o_tready,
    output logic                     o_uart_tx,
    output logic                     o_busy,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int DIV = uart_div(CLK_FREQ_HZ, BAUD);
    localparam int CW  = $clog2(DIV);
    localparam int LW  = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    uart_state_t    state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     bit_q, bit_d;
    logic [DW-1:0]  sh_q, sh_d;
    logic           par_q, par_d;
    logic           stop_q, stop_d;
    eol_t           pend_q, pend_d;
    eol_t           after_q, after_d;

    logic [8:0]     fifo_dout;
    logic           fifo_full;
    logic           fifo_empty;
    logic [LW-1:0]  fifo_level;
    logic           push;
    logic           pop;
    logic           load;
    logic [7:0]     load_byte;
    logic           tick;
    logic           tready_q;

    assign push     = i_tvalid & tready_q & ~fifo_full;
    assign tick     = (cnt_q == '0);
    assign o_tready = tready_q;
    assign o_level  = fifo_level;
    assign o_busy   = (state_q != ST_IDLE) | (pend_q != EOL_NONE);

    corescore_sync_fifo #(
        .WIDTH (9),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (push),
        .pop   (pop),
        .din   ({i_tlast, i_tdata}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // tready tracks the post-edge occupancy so upstream never sees a stale slot.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tready_q <= 1'b0;
        end else begin
            tready_q <= ((fifo_level + LW'(push) - LW'(pop)) != LW'(DEPTH));
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            stop_q  <= 1'b0;
            pend_q  <= EOL_NONE;
            after_q <= EOL_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            stop_q  <= stop_d;
            pend_q  <= pend_d;
            after_q <= after_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        par_d     = par_q;
        stop_d    = stop_q;
        pend_d    = pend_q;
        after_d   = after_q;
        pop       = 1'b0;
        load      = 1'b0;
        load_byte = 8'h00;

        case (state_q)
            ST_IDLE: begin
                // A pending CR/LF always wins over queued stream bytes.
                if (pend_q != EOL_NONE) begin
                    load      = 1'b1;
                    load_byte = (pend_q == EOL_CR) ? ASCII_CR : ASCII_LF;
                    after_d   = (pend_q == EOL_CR) ? EOL_LF : EOL_NONE;
                    pend_d    = EOL_NONE;
                end else if (!fifo_empty) begin
                    load      = 1'b1;
                    pop       = 1'b1;
                    load_byte = fifo_dout[7:0];
                    after_d   = (fifo_dout[8] && EOL_MODE != 0) ? EOL_CR : EOL_NONE;
                end
                if (load) begin
                    sh_d    = load_byte[DW-1:0];
                    par_d   = (^load_byte[DW-1:0]) ^ (PARITY == int'(PAR_ODD));
                    cnt_d   = RELOAD;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    cnt_d   = RELOAD;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DATA: begin
                if (tick) begin
                    cnt_d = RELOAD;
                    sh_d  = sh_q >> 1;
                    if (bit_q == 3'(DW - 1)) begin
                        stop_d  = 1'b0;
                        state_d = (PARITY != 0) ? ST_PAR : ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_PAR: begin
                if (tick) begin
                    cnt_d   = RELOAD;
                    stop_d  = 1'b0;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_STOP: begin
                if (tick) begin
                    cnt_d = RELOAD;
                    if (stop_q == 1'(STOP_BITS - 1)) begin
                        pend_d  = after_q;
                        state_d = ST_IDLE;
                    end else begin
                        stop_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        case (state_q)
            ST_START: o_uart_tx = 1'b0;
            ST_DATA:  o_uart_tx = sh_q[0];
            ST_PAR:   o_uart_tx = par_q;
            default:  o_uart_tx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_corescore_uart_emitter.sv
// Scoreboarded bench: accepted beats queue expected frames, a line receiver checks them.
// Directed phases also pin down latency, backpressure, CR/LF chaining and reset behaviour.
module tb_corescore_uart_emitter;

    localparam int DW        = 8;
    localparam int DEPTH     = 16;
    localparam int CLK_HZ    = 1000;
    localparam int BAUD      = 100;
    localparam int PARITY    = 2;
    localparam int STOP_BITS = 1;
    localparam int EOL_MODE  = 1;
    localparam int DIV       = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int NB        = 1 + DW + 1 + STOP_BITS;
    localparam int FRAME     = NB * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tdata = 8'h00;
    logic       tlast = 1'b0;
    logic       tvalid = 1'b0;
    logic       tready;
    logic       tx;
    logic       busy;
    logic [4:0] level;

    corescore_uart_emitter #(
        .DW          (DW),
        .DEPTH       (DEPTH),
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD        (BAUD),
        .PARITY      (PARITY),
        .STOP_BITS   (STOP_BITS),
        .EOL_MODE    (EOL_MODE)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_tdata   (tdata),
        .i_tlast   (tlast),
        .i_tvalid  (tvalid),
        .o_tready  (tready),
        .o_uart_tx (tx),
        .o_busy    (busy),
        .o_level   (level)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    task automatic checkOutput(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, expv, $time);
        end
    endtask

    // Expected line traffic for one accepted beat: the byte, then CR/LF after tlast.
    task automatic modelPush(input logic [7:0] b, input logic last);
        exp_q.push_back(b);
        if (last && EOL_MODE != 0) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    // Called at a falling edge; returns the edge count seen after the accepting edge.
    task automatic applyStimulus(input logic [7:0] d, input logic l, output int acc_edge);
        logic ready;
        tdata    = d;
        tlast    = l;
        tvalid   = 1'b1;
        acc_edge = -1;
        for (int w = 0; w < 4 * FRAME && acc_edge < 0; w++) begin
            ready = tready;
            @(negedge clk);
            if (ready) begin
                acc_edge = edge_cnt;
                modelPush(d, l);
            end
        end
        if (acc_edge < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: beat %0h never accepted", d);
        end
    endtask

    task automatic waitCycle(input int a, input int k);
        while (edge_cnt < a + k - 1) @(negedge clk);
    endtask

    logic rx_active = 1'b0;
    logic rx_bits[NB];
    int   rx_cnt = 0;

    task automatic finishFrame();
        logic [7:0] got;
        logic [7:0] e;
        int         ones;
        got = '0;
        for (int i = 0; i < DW; i++) got[i] = rx_bits[1 + i];
        checkOutput("frame_start", int'(rx_bits[0]), 0);
        checkOutput("frame_stop", int'(rx_bits[NB-1]), 1);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_frame: got data %0h with nothing queued", got);
        end else begin
            e    = exp_q.pop_front();
            ones = $countones(e);
            checkOutput("frame_data", int'(got), int'(e));
            checkOutput("frame_parity", int'(rx_bits[DW+1]),
                        (PARITY == 2) ? (ones % 2) : (1 - ones % 2));
        end
    endtask

    // Line receiver sampling the middle of every bit cell.
    always @(negedge clk) begin
        if (rst) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (tx === 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % DIV == DIV / 2) begin
                rx_bits[rx_cnt / DIV] = tx;
                if (rx_cnt / DIV == NB - 1) begin
                    finishFrame();
                    rx_active = 1'b0;
                end
            end
        end
    end

    task automatic waitIdle(input string name);
        int w;
        w = 0;
        while (!(exp_q.size() == 0 && !rx_active && !busy && level == 0) && w < 60 * FRAME) begin
            @(negedge clk);
            w++;
        end
        if (w >= 60 * FRAME) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: drain timeout, %0d frames outstanding", name, exp_q.size());
        end
    endtask

    initial begin
        int a;
        int a1;
        int acc;
        int busy_drops;
        int level_max;
        int low_cycles;

        // Reset held for three cycles from power-up.
        repeat (3) @(negedge clk);
        checkOutput("rst_tx", int'(tx), 1);
        checkOutput("rst_tready", int'(tready), 0);
        checkOutput("rst_level", int'(level), 0);
        checkOutput("rst_busy", int'(busy), 0);
        rst = 1'b0;
        #1;
        checkOutput("rst_tready_before_edge", int'(tready), 0);
        @(negedge clk);
        checkOutput("tready_after_release", int'(tready), 1);

        // Single byte latency and bit timing.
        applyStimulus(8'h55, 1'b0, a);
        tvalid = 1'b0;
        checkOutput("single_c1_tx", int'(tx), 1);
        checkOutput("single_c1_level", int'(level), 1);
        checkOutput("single_c1_busy", int'(busy), 0);
        waitCycle(a, 2);
        checkOutput("single_c2_tx", int'(tx), 0);
        checkOutput("single_c2_busy", int'(busy), 1);
        checkOutput("single_c2_level", int'(level), 0);
        waitCycle(a, 1 + DIV);
        checkOutput("single_start_end_tx", int'(tx), 0);
        waitCycle(a, 2 + DIV);
        checkOutput("single_bit0_tx", int'(tx), 1);
        waitCycle(a, 2 + DIV + DIV);
        checkOutput("single_bit1_tx", int'(tx), 0);
        waitCycle(a, 1 + FRAME);
        checkOutput("single_busy_last", int'(busy), 1);
        waitCycle(a, 2 + FRAME);
        checkOutput("single_busy_fall", int'(busy), 0);
        waitIdle("single");

        // Parity corner values.
        applyStimulus(8'h07, 1'b0, a);
        applyStimulus(8'hFF, 1'b0, a);
        applyStimulus(8'h00, 1'b0, a);
        tvalid = 1'b0;
        waitIdle("parity");

        // Backpressure: 20 beats offered back to back.
        a1 = 0;
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), 1'b0, acc);
            if (i == 1) a1 = acc;
            if (i == 17) begin
                checkOutput("bp_level_full", int'(level), DEPTH);
                checkOutput("bp_tready_low", int'(tready), 0);
            end
            if (i == 18) checkOutput("bp_beat18_edge", acc - a1, FRAME + 3);
        end
        tvalid = 1'b0;
        waitIdle("backpressure");

        // CR/LF appended after a tlast byte.
        applyStimulus(8'h41, 1'b1, a);
        tvalid     = 1'b0;
        busy_drops = 0;
        level_max  = 0;
        for (int k = 2; k < 4 + 3 * FRAME; k++) begin
            waitCycle(a, k);
            if (!busy) busy_drops++;
            if (int'(level) > level_max) level_max = int'(level);
        end
        checkOutput("eol_busy_drops", busy_drops, 0);
        checkOutput("eol_level_over_1", int'(level_max > 1), 0);
        waitCycle(a, 4 + 3 * FRAME);
        checkOutput("eol_busy_fall", int'(busy), 0);
        waitIdle("eol");

        // Randomised traffic with gaps and occasional tlast.
        for (int i = 0; i < 40; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0), acc);
            if ($urandom_range(0, 2) == 0) begin
                tvalid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        tvalid = 1'b0;
        waitIdle("random");

        // Reset during data bit 3 with further bytes queued.
        applyStimulus(8'h00, 1'b0, a);
        for (int i = 0; i < 3; i++) applyStimulus(8'($urandom_range(0, 255)), 1'b0, acc);
        tvalid = 1'b0;
        waitCycle(a, 2 + 4 * DIV + DIV / 2);
        checkOutput("midrst_line_low", int'(tx), 0);
        rst = 1'b1;
        #1;
        checkOutput("midrst_tx_async", int'(tx), 1);
        checkOutput("midrst_level", int'(level), 0);
        checkOutput("midrst_busy", int'(busy), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        low_cycles = 0;
        for (int k = 0; k < 3 * FRAME; k++) begin
            @(negedge clk);
            if (!tx) low_cycles++;
        end
        checkOutput("midrst_no_frames", low_cycles, 0);
        checkOutput("midrst_level_after", int'(level), 0);
        checkOutput("midrst_tready_after", int'(tready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
